// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes, state
// encoding, ALU operation codes and PC source selects.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Last state of every legal instruction; leaving it retires the instruction.
  function automatic logic is_retire_state(input state_t s);
    return (s == S_MEM_WB) || (s == S_MEM_WRITE) || (s == S_R_WB) ||
           (s == S_BRANCH) || (s == S_JUMP) || (s == S_ADDI_WB);
  endfunction

endpackage

// File: rtl/registrador_instrucao.sv
// 32-bit instruction register with write enable and synchronous reset.
module registrador_instrucao (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] d,
  output logic [31:0] q
);

  // Capture the fetched word on write enable, clear on reset.
  always_ff @(posedge clk) begin
    if (reset) q <= 32'd0;
    else if (we) q <= d;
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multi-cycle MIPS control unit: instruction register, state sequencer,
// Moore-decoded datapath strobes and a retired-instruction counter.
module controle_multiciclo
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        zero,
  output logic        pc_write,
  output logic [1:0]  pc_source,
  output logic        ir_write,
  output logic [31:0] ir,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [15:0] retired
);

  state_t     state_q, state_n;
  logic [5:0] opcode;

  assign opcode = ir[31:26];
  assign state  = state_q;

  registrador_instrucao u_ir (
    .clk   (clk),
    .reset (reset),
    .we    (ir_write),
    .d     (instruction),
    .q     (ir)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_n;
  end

  // Next-state and Moore output decode; reset forces FETCH values with strobes off.
  always_comb begin
    state_n    = S_FETCH;
    pc_write   = 1'b0;
    pc_source  = PC_ALU;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
        state_n   = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here while the opcode is dispatched.
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_n = S_MEM_ADDR;
          OP_RTYPE:     state_n = S_EXECUTE;
          OP_BEQ:       state_n = S_BRANCH;
          OP_J:         state_n = S_JUMP;
          OP_ADDI:      state_n = S_ADDI_EXEC;
          default: begin
            illegal = 1'b1;
            state_n = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_n   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        state_n  = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: mem_write = 1'b1;
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_n   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PC_ALUOUT;
        pc_write  = zero;
      end
      S_JUMP: begin
        pc_source = PC_JUMP;
        pc_write  = 1'b1;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_n   = S_ADDI_WB;
      end
      S_ADDI_WB: reg_write = 1'b1;
      default: state_n = S_FETCH;
    endcase
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;
      pc_source  = PC_ALU;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b01;
      alu_op     = ALU_ADD;
    end
  end

  // Retired-instruction counter, bumped when leaving a final instruction state.
  always_ff @(posedge clk) begin
    if (reset) retired <= 16'd0;
    else if (is_retire_state(state_q)) retired <= retired + 16'd1;
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: expected per-cycle output vectors
// are queued when an instruction is driven and compared cycle by cycle.
module tb_controle_multiciclo;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        zero;
  logic        pc_write, ir_write, mem_read, mem_write, reg_write;
  logic        reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0]  pc_source, alu_src_b, alu_op;
  logic [31:0] ir;
  logic [3:0]  state;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_ret = 16'd0;
  logic [18:0] expq[$];
  logic [18:0] cur;

  controle_multiciclo dut (
    .clk(clk), .reset(reset), .instruction(instruction), .zero(zero),
    .pc_write(pc_write), .pc_source(pc_source), .ir_write(ir_write), .ir(ir),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  assign cur = {state, pc_write, pc_source, ir_write, mem_read, mem_write,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected output vector for a state, taken from the state/strobe table.
  function automatic logic [18:0] exp_vec(input logic [3:0] s, input logic z,
                                          input logic ill, input logic rst);
    logic pw, irw, mr, mw, rw, rd, m2r, sa;
    logic [1:0] ps, sb, op;
    {pw, irw, mr, mw, rw, rd, m2r, sa} = 8'd0;
    ps = 2'b00; sb = 2'b00; op = 2'b00;
    case (s)
      4'd0:  begin irw = 1; sb = 2'b01; pw = 1; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  mr = 1;
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  mw = 1;
      4'd6:  begin sa = 1; op = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin sa = 1; op = 2'b01; ps = 2'b01; pw = z; end
      4'd9:  begin ps = 2'b10; pw = 1; end
      4'd10: begin sa = 1; sb = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    if (rst) begin
      {pw, irw, mr, mw, rw, rd, m2r, sa} = 8'd0;
      ps = 2'b00; sb = 2'b01; op = 2'b00; ill = 1'b0;
    end
    return {s, pw, ps, irw, mr, mw, rw, rd, m2r, sa, sb, op, ill};
  endfunction

  // Queue the expected state sequence of one instruction; returns 1 if it retires.
  function automatic logic push_instr(input logic [31:0] ins, input logic z);
    case (ins[31:26])
      6'b100011: begin
        expq.push_back(exp_vec(0, z, 0, 0)); expq.push_back(exp_vec(1, z, 0, 0));
        expq.push_back(exp_vec(2, z, 0, 0)); expq.push_back(exp_vec(3, z, 0, 0));
        expq.push_back(exp_vec(4, z, 0, 0));
      end
      6'b101011: begin
        expq.push_back(exp_vec(0, z, 0, 0)); expq.push_back(exp_vec(1, z, 0, 0));
        expq.push_back(exp_vec(2, z, 0, 0)); expq.push_back(exp_vec(5, z, 0, 0));
      end
      6'b000000: begin
        expq.push_back(exp_vec(0, z, 0, 0)); expq.push_back(exp_vec(1, z, 0, 0));
        expq.push_back(exp_vec(6, z, 0, 0)); expq.push_back(exp_vec(7, z, 0, 0));
      end
      6'b001000: begin
        expq.push_back(exp_vec(0, z, 0, 0)); expq.push_back(exp_vec(1, z, 0, 0));
        expq.push_back(exp_vec(10, z, 0, 0)); expq.push_back(exp_vec(11, z, 0, 0));
      end
      6'b000100: begin
        expq.push_back(exp_vec(0, z, 0, 0)); expq.push_back(exp_vec(1, z, 0, 0));
        expq.push_back(exp_vec(8, z, 0, 0));
      end
      6'b000010: begin
        expq.push_back(exp_vec(0, z, 0, 0)); expq.push_back(exp_vec(1, z, 0, 0));
        expq.push_back(exp_vec(9, z, 0, 0));
      end
      default: begin
        expq.push_back(exp_vec(0, z, 0, 0)); expq.push_back(exp_vec(1, z, 1, 0));
        return 1'b0;
      end
    endcase
    return 1'b1;
  endfunction

  // Drive one instruction from FETCH and compare every cycle until it completes.
  task automatic run_instr(input string nm, input logic [31:0] ins, input logic z);
    logic counts;
    int idx;
    instruction = ins;
    zero = z;
    counts = push_instr(ins, z);
    idx = 0;
    while (expq.size() > 0) begin
      chk(nm, 32'(cur), 32'(expq.pop_front()));
      if (idx == 1) chk({nm, "_ir"}, ir, ins);
      @(posedge clk); #1;
      idx++;
    end
    if (counts) exp_ret = exp_ret + 16'd1;
    chk({nm, "_retired"}, 32'(retired), 32'(exp_ret));
  endtask

  initial begin
    reset = 1'b1;
    instruction = 32'h8C09_0004;
    zero = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("reset_outs", 32'(cur), 32'(exp_vec(0, 0, 0, 1)));
    end
    chk("reset_ir", ir, 32'd0);
    chk("reset_retired", 32'(retired), 32'd0);
    reset = 1'b0;
    #1;

    run_instr("lw", 32'h8C09_0004, 1'b0);
    run_instr("beq_taken", 32'h1109_0002, 1'b1);
    run_instr("beq_not_taken", 32'h1109_0002, 1'b0);
    run_instr("j", 32'h0800_0001, 1'b0);
    run_instr("rtype", 32'h012A_4020, 1'b1);
    run_instr("sw", 32'hAD09_0008, 1'b1);
    run_instr("addi", 32'h2129_0005, 1'b0);
    run_instr("illegal", 32'hFC00_0000, 1'b0);
    run_instr("lw_after_illegal", 32'h8C0A_0010, 1'b1);

    // Abort a load in MEM_READ with reset.
    instruction = 32'h8C09_0004;
    zero = 1'b0;
    void'(push_instr(instruction, 1'b0));
    for (int i = 0; i < 3; i++) begin
      chk("abort_seq", 32'(cur), 32'(expq.pop_front()));
      @(posedge clk); #1;
    end
    expq.delete();
    reset = 1'b1;
    #1;
    chk("abort_in_reset", 32'(cur), 32'(exp_vec(3, 0, 0, 1)));
    @(posedge clk); #1;
    chk("abort_state", 32'(cur), 32'(exp_vec(0, 0, 0, 1)));
    chk("abort_ir", ir, 32'd0);
    chk("abort_retired", 32'(retired), 32'd0);
    reset = 1'b0;
    exp_ret = 16'd0;
    #1;
    chk("abort_resume", 32'(cur), 32'(exp_vec(0, 0, 0, 0)));
    run_instr("j_after_abort", 32'h0800_0002, 1'b0);

    // Counter wrap: preload 0xFFFF while a jump sits in JUMP.
    instruction = 32'h0800_0003;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wrap_state", 32'(state), 32'd9);
    force dut.retired = 16'hFFFF;
    #1;
    release dut.retired;
    chk("wrap_preload", 32'(retired), 32'h0000_FFFF);
    @(posedge clk); #1;
    chk("wrap_zero", 32'(retired), 32'd0);
    exp_ret = 16'd0;
    run_instr("j_after_wrap", 32'h0800_0004, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multi-cycle MIPS control unit with an integrated instruction register, sitting directly downstream of the instruction memory. It latches the 32-bit word fetched at the current PC, decodes its opcode, and sequences the datapath through fetch, decode, execute, memory and write-back states. It drives the strobes for the PC register, ALU, data memory and register file, and produces the PC write enable that feeds the PC register.

## Interface
- No parameters; instruction width fixed at 32, PC at 5 bits (byte address, 8 words).
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- instruction  in  32  word from instruction memory at current PC
- zero  in  1  ALU zero flag, valid in BRANCH state
- pc_write  out  1  load PC register
- pc_source  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- ir_write  out  1  IR capture strobe (also exported)
- ir  out  32  latched instruction; fields opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0]
- mem_read, mem_write  out  1 each  data memory strobes
- reg_write  out  1  register file write
- reg_dst  out  1  0 rt, 1 rd
- mem_to_reg  out  1  0 ALUOut, 1 MDR
- alu_src_a  out  1  0 PC, 1 rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 use funct
- illegal  out  1  one-cycle pulse on unknown opcode
- state  out  4  current state encoding
- retired  out  16  retired-instruction counter

## Operation
- States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11.
- FETCH: ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, pc_write=1; next DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target). Dispatch on ir opcode: 100011 lw / 101011 sw -> MEM_ADDR; 000000 -> EXECUTE; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDI_EXEC; other -> FETCH with illegal=1.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: mem_read=1 -> MEM_WB. MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEM_WRITE: mem_write=1 -> FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write=zero -> FETCH.
- JUMP: pc_source=10, pc_write=1 -> FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB. ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- Unlisted outputs are 0 in each state (Moore, decoded from state register only, except pc_write in BRANCH).
- ir captures instruction on the rising edge where ir_write=1; holds otherwise.
- retired increments by 1 on the edge leaving MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, ADDI_WB; illegal opcodes do not count; wraps 0xFFFF -> 0x0000.

## Timing
- Reset (sampled on posedge): state=FETCH, ir=0, retired=0. While reset is high, pc_write, ir_write, mem_read, mem_write, reg_write and illegal are forced to 0; other outputs carry FETCH values.
- Reset asserted mid-instruction aborts it: no counter increment; FETCH strobes resume the cycle after reset deasserts.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- ir changes one cycle after FETCH; DECODE dispatch uses the registered ir, never the live instruction input.
- zero is sampled combinationally only during BRANCH; ignored elsewhere.

## Structure
- Shared package mips_pkg holds opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), the 4-bit state encoding, alu_op codes, and pc_source codes.
- One sub-module: registrador_instrucao (32-bit register with write enable and synchronous reset), instantiated for ir.

## Test plan
- Reset held 3 cycles, then released with instruction=0x8C090004 (lw): states 0,1,2,3,4,0; mem_read only in state 3; reg_write with mem_to_reg=1 in state 4; retired=1.
- beq 0x11090002 with zero=1: states 0,1,8; pc_write=1 and pc_source=01 in state 8. Repeat with zero=0: pc_write=0 in state 8; retired counts both.
- j 0x08000001: states 0,1,9; pc_write=1, pc_source=10; R-type 0x012A4020: EXECUTE with alu_op=10, then R_WB with reg_dst=1.
- Opcode 0x3F: illegal=1 for exactly the DECODE cycle, next state FETCH, retired unchanged.
- Reset asserted during MEM_READ: next state FETCH, ir=0, retired=0, no reg_write pulse.
- Preload retired to 0xFFFF via 65535 j instructions (or force): next retirement yields 0x0000.
